// File: rtl/sd_rx_pkg.sv
// Shared types and constants for the 4-bit SD data-line receiver.
package sd_rx_pkg;

    localparam int unsigned BLK_LEN_W = 12;
    localparam int unsigned BLK_CNT_W = 8;
    localparam int unsigned TOUT_W    = 16;
    localparam int unsigned NUM_LINES = 4;
    localparam int unsigned CRC_W     = 16;
    localparam int unsigned NIB_CNT_W = BLK_LEN_W + 1;
    localparam int unsigned BIT_CNT_W = 4;

    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h1021;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        ENDB,
        FINISH
    } rx_state_e;

    typedef struct packed {
        logic crc_err;
        logic end_err;
        logic tout_err;
        logic ovr_err;
    } rx_flags_t;

endpackage

// File: rtl/sd_data_rx_4bit_if.sv
// Control, card-side and FIFO-side signals of the SD data receiver.
interface sd_data_rx_4bit_if
    import sd_rx_pkg::*;
();

    logic                 start;
    logic                 abort;
    logic [BLK_LEN_W-1:0] blk_len;
    logic [BLK_CNT_W-1:0] blk_cnt;
    logic [TOUT_W-1:0]    timeout;
    logic [3:0]           dat_i;
    logic                 fifo_full;
    logic [3:0]           d;
    logic                 wr;
    logic                 busy;
    logic                 done;
    logic                 crc_err;
    logic                 end_err;
    logic                 tout_err;
    logic                 ovr_err;

    modport master (
        output start, abort, blk_len, blk_cnt, timeout, dat_i, fifo_full,
        input  d, wr, busy, done, crc_err, end_err, tout_err, ovr_err
    );

    modport slave (
        input  start, abort, blk_len, blk_cnt, timeout, dat_i, fifo_full,
        output d, wr, busy, done, crc_err, end_err, tout_err, ovr_err
    );

endinterface

// File: rtl/sd_data_rx_4bit_crc16.sv
// Bit-serial CRC16-CCITT (init 0) for one SD data line.
module sd_crc16_serial
    import sd_rx_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] crc_q, crc_d;
    logic             fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[CRC_W-1] ^ bit_i;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_data_rx_4bit.sv
// SD 4-bit data receiver: start-bit detect, nibble streaming to the RX FIFO,
// per-line CRC16 and end-bit check, start-bit timeout, multi-block sequencing.
module sd_data_rx_4bit
    import sd_rx_pkg::*;
(
    input  logic              sd_clk,
    input  logic              rst,
    sd_data_rx_4bit_if.slave  bus
);

    rx_state_e                        state_q, state_d;
    logic [BLK_LEN_W-1:0]             blk_len_q, blk_len_d;
    logic [BLK_CNT_W-1:0]             blk_left_q, blk_left_d;
    logic [TOUT_W-1:0]                tout_len_q, tout_len_d;
    logic [TOUT_W-1:0]                tout_cnt_q, tout_cnt_d;
    logic [NIB_CNT_W-1:0]             nib_cnt_q, nib_cnt_d;
    logic [BIT_CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic [NUM_LINES-1:0][CRC_W-1:0]  rxcrc_q, rxcrc_d;
    logic [3:0]                       d_q, d_d;
    logic                             wr_q, wr_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    rx_flags_t                        flags_q, flags_d;

    logic                             crc_clr_c;
    logic                             crc_en_c;
    logic                             nib_last_c;
    logic [NUM_LINES-1:0][CRC_W-1:0]  crc_val;

    for (genvar g = 0; g < int'(NUM_LINES); g++) begin : g_crc
        sd_crc16_serial u_crc (
            .clk   (sd_clk),
            .rst   (rst),
            .clr_i (crc_clr_c),
            .en_i  (crc_en_c),
            .bit_i (bus.dat_i[g]),
            .crc_o (crc_val[g])
        );
    end

    // Two nibbles per byte; counter is one bit wider than the byte length.
    assign nib_last_c = (nib_cnt_q == ({blk_len_q, 1'b0} - NIB_CNT_W'(1)));

    always_comb begin
        state_d    = state_q;
        blk_len_d  = blk_len_q;
        blk_left_d = blk_left_q;
        tout_len_d = tout_len_q;
        tout_cnt_d = tout_cnt_q;
        nib_cnt_d  = nib_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        rxcrc_d    = rxcrc_q;
        d_d        = d_q;
        flags_d    = flags_q;
        wr_d       = 1'b0;
        crc_clr_c  = 1'b0;
        crc_en_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    blk_len_d  = bus.blk_len;
                    blk_left_d = (bus.blk_cnt == '0) ? BLK_CNT_W'(1) : bus.blk_cnt;
                    tout_len_d = bus.timeout;
                    tout_cnt_d = bus.timeout;
                    flags_d    = '0;
                    state_d    = WAIT_START;
                end
            end
            WAIT_START: begin
                if (bus.dat_i == 4'h0) begin
                    crc_clr_c = 1'b1;
                    nib_cnt_d = '0;
                    state_d   = DATA;
                end else if (tout_cnt_q <= TOUT_W'(1)) begin
                    tout_cnt_d       = '0;
                    flags_d.tout_err = 1'b1;
                    state_d          = FINISH;
                end else begin
                    tout_cnt_d = tout_cnt_q - TOUT_W'(1);
                end
            end
            DATA: begin
                // A full FIFO drops the write but the block is still clocked through the CRCs.
                crc_en_c  = 1'b1;
                d_d       = bus.dat_i;
                nib_cnt_d = nib_cnt_q + NIB_CNT_W'(1);
                if (bus.fifo_full) flags_d.ovr_err = 1'b1;
                else               wr_d            = 1'b1;
                if (nib_last_c) begin
                    bit_cnt_d = '0;
                    state_d   = CRC;
                end
            end
            CRC: begin
                for (int i = 0; i < int'(NUM_LINES); i++) begin
                    rxcrc_d[i] = {rxcrc_q[i][CRC_W-2:0], bus.dat_i[i]};
                end
                bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                if (bit_cnt_q == '1) state_d = ENDB;
            end
            ENDB: begin
                if (bus.dat_i != 4'hF)  flags_d.end_err = 1'b1;
                if (rxcrc_q != crc_val) flags_d.crc_err = 1'b1;
                if ((blk_left_q > BLK_CNT_W'(1)) && (flags_d == '0)) begin
                    blk_left_d = blk_left_q - BLK_CNT_W'(1);
                    tout_cnt_d = tout_len_q;
                    state_d    = WAIT_START;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything, including a coincident start, and keeps the flags.
        if (bus.abort) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            flags_d = flags_q;
        end

        busy_d = (state_d == WAIT_START) || (state_d == DATA) ||
                 (state_d == CRC) || (state_d == ENDB);
        done_d = (state_d == FINISH);
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_len_q  <= '0;
            blk_left_q <= '0;
            tout_len_q <= '0;
            tout_cnt_q <= '0;
            nib_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rxcrc_q    <= '0;
            d_q        <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            blk_len_q  <= blk_len_d;
            blk_left_q <= blk_left_d;
            tout_len_q <= tout_len_d;
            tout_cnt_q <= tout_cnt_d;
            nib_cnt_q  <= nib_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rxcrc_q    <= rxcrc_d;
            d_q        <= d_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            flags_q    <= flags_d;
        end
    end

    assign bus.d        = d_q;
    assign bus.wr       = wr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.crc_err  = flags_q.crc_err;
    assign bus.end_err  = flags_q.end_err;
    assign bus.tout_err = flags_q.tout_err;
    assign bus.ovr_err  = flags_q.ovr_err;

endmodule

// File: tb/tb_sd_data_rx_4bit.sv
// Scoreboard bench for sd_data_rx_4bit: stimulus pushes expected nibbles and
// end-of-transfer flags; a negedge monitor pops and compares on wr / done.
module tb_sd_data_rx_4bit;
    import sd_rx_pkg::*;

    logic sd_clk = 1'b0;
    logic rst    = 1'b1;

    sd_data_rx_4bit_if bus ();

    sd_data_rx_4bit dut (
        .sd_clk (sd_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sd_clk = ~sd_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_done_q[$];   // {crc_err, end_err, tout_err, ovr_err}

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic [15:0] sh;
        sh = {c[14:0], 1'b0};
        return (c[15] ^ b) ? (sh ^ 16'h1021) : sh;
    endfunction

    function automatic logic [3:0] pat(input int mode, input int k);
        case (mode)
            0:       return 4'h0;
            1:       return 4'hF;
            2:       return 4'(k);
            default: return 4'(k + 9);
        endcase
    endfunction

    // Monitor: every wr pops one expected nibble, every done pops one flag record.
    always @(negedge sd_clk) begin
        if (!rst) begin
            if (bus.wr) begin
                if (exp_q.size() == 0) chk("wr_unexpected", 1, 0);
                else                   chk("nibble", int'(bus.d), int'(exp_q.pop_front()));
            end
            if (bus.done) begin
                done_seen++;
                if (exp_done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_flags", int'({bus.crc_err, bus.end_err, bus.tout_err, bus.ovr_err}),
                         int'(exp_done_q.pop_front()));
            end
        end
    end

    task automatic do_start(input int len, input int cnt, input int tout);
        @(negedge sd_clk);
        bus.blk_len = BLK_LEN_W'(len);
        bus.blk_cnt = BLK_CNT_W'(cnt);
        bus.timeout = TOUT_W'(tout);
        bus.start   = 1'b1;
        @(negedge sd_clk);
        bus.start = 1'b0;
        chk("busy_after_start", int'(bus.busy), 1);
    endtask

    // Start bit, nn data nibbles, per-line CRC (optionally corrupted), end nibble.
    task automatic send_block(input int nn, input int mode, input int full_idx,
                              input logic [3:0] endn, input int flip_line, input int flip_bit);
        logic [15:0] c [4];
        logic [3:0]  nib;
        for (int i = 0; i < 4; i++) c[i] = 16'h0;
        @(negedge sd_clk);
        bus.dat_i = 4'h0;
        for (int k = 0; k < nn; k++) begin
            nib = pat(mode, k);
            @(negedge sd_clk);
            bus.dat_i     = nib;
            bus.fifo_full = (k == full_idx);
            if (k != full_idx) exp_q.push_back(nib);
            for (int i = 0; i < 4; i++) c[i] = crc_step(c[i], nib[i]);
        end
        if (flip_line >= 0) c[flip_line][flip_bit] = ~c[flip_line][flip_bit];
        for (int b = 15; b >= 0; b--) begin
            @(negedge sd_clk);
            bus.fifo_full = 1'b0;
            for (int i = 0; i < 4; i++) bus.dat_i[i] = c[i][b];
        end
        @(negedge sd_clk);
        bus.dat_i = endn;
        @(negedge sd_clk);
        bus.dat_i = 4'hF;
    endtask

    task automatic wait_done(input int base, input int budget);
        int t = 0;
        while (done_seen == base && t < budget) begin
            @(negedge sd_clk);
            t++;
        end
        chk("done_within_budget", int'(done_seen != base), 1);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        bus.start = 1'b0; bus.abort = 1'b0; bus.blk_len = '0; bus.blk_cnt = '0;
        bus.timeout = '0; bus.dat_i = 4'hF; bus.fifo_full = 1'b0;

        // Reset values
        repeat (3) @(negedge sd_clk);
        chk("rst_d", int'(bus.d), 0);
        chk("rst_wr", int'(bus.wr), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_flags", int'({bus.crc_err, bus.end_err, bus.tout_err, bus.ovr_err}), 0);
        rst = 1'b0;
        @(negedge sd_clk);

        // Start coincident with abort is ignored
        bus.start = 1'b1; bus.abort = 1'b1; bus.blk_len = 12'd4; bus.blk_cnt = 8'd1; bus.timeout = 16'd50;
        @(negedge sd_clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        chk("start_abort_busy", int'(bus.busy), 0);
        repeat (60) @(negedge sd_clk);
        chk("start_abort_no_done", done_seen, 0);

        // Zero block: 1024 zero nibbles, CRC 0 on every line
        base = done_seen;
        exp_done_q.push_back(4'b0000);
        do_start(512, 1, 1000);
        send_block(1024, 0, -1, 4'hF, -1, 0);
        wait_done(base, 50);

        // 512 bytes of 0xFF per line, CRC 0x7FA1 (computed and constant agree)
        begin
            logic [15:0] c;
            c = 16'h0;
            for (int k = 0; k < 4096; k++) c = crc_step(c, 1'b1);
            chk("ref_crc_7fa1", int'(c), 32'h7FA1);
        end
        base = done_seen;
        exp_done_q.push_back(4'b0000);
        do_start(2048, 1, 1000);
        send_block(4096, 1, -1, 4'hF, -1, 0);
        wait_done(base, 50);

        // Same block with one CRC bit flipped on line 2
        base = done_seen;
        exp_done_q.push_back(4'b1000);
        do_start(2048, 1, 1000);
        send_block(4096, 1, -1, 4'hF, 2, 5);
        wait_done(base, 50);

        // Start-bit timeout of 100 cycles with DAT idle high
        base = done_seen;
        exp_done_q.push_back(4'b0010);
        do_start(4, 1, 100);
        t = 1;
        while (!bus.done && t < 300) begin
            @(negedge sd_clk);
            t++;
        end
        chk("tout_latency_ok", int'(t >= 99 && t <= 101), 1);
        @(negedge sd_clk);
        chk("tout_done_once", done_seen - base, 1);
        chk("tout_busy_low", int'(bus.busy), 0);

        // Three 4-byte blocks of nibbles 0..7 with 20-cycle gaps, one done
        base = done_seen;
        exp_done_q.push_back(4'b0000);
        do_start(4, 3, 50);
        for (int b = 0; b < 3; b++) begin
            send_block(8, 2, -1, 4'hF, -1, 0);
            if (b < 2) begin
                repeat (20) @(negedge sd_clk);
                chk("multi_busy_in_gap", int'(bus.busy), 1);
            end
        end
        wait_done(base, 50);
        repeat (10) @(negedge sd_clk);
        chk("multi_single_done", done_seen - base, 1);

        // FIFO full on 3rd nibble: write dropped, overrun, stop after first of two blocks
        base = done_seen;
        exp_done_q.push_back(4'b0001);
        do_start(4, 2, 100);
        send_block(8, 3, 2, 4'hF, -1, 0);
        wait_done(base, 50);
        repeat (150) @(negedge sd_clk);
        chk("ovr_single_done", done_seen - base, 1);
        chk("ovr_flag_held", int'(bus.ovr_err), 1);

        // Bad end bit on one line
        base = done_seen;
        exp_done_q.push_back(4'b0100);
        do_start(2, 1, 100);
        send_block(4, 2, -1, 4'h7, -1, 0);
        wait_done(base, 50);

        // Abort in the middle of DATA
        base = done_seen;
        do_start(4, 1, 100);
        @(negedge sd_clk); bus.dat_i = 4'h0;
        @(negedge sd_clk); bus.dat_i = 4'hA; exp_q.push_back(4'hA);
        @(negedge sd_clk); bus.dat_i = 4'hB; exp_q.push_back(4'hB);
        @(negedge sd_clk); bus.dat_i = 4'hC; bus.abort = 1'b1;
        @(negedge sd_clk); bus.abort = 1'b0; bus.dat_i = 4'hF;
        chk("abort_wr_low", int'(bus.wr), 0);
        chk("abort_busy_low", int'(bus.busy), 0);
        chk("abort_flags_held", int'({bus.crc_err, bus.end_err, bus.tout_err, bus.ovr_err}), 0);
        repeat (150) @(negedge sd_clk);
        chk("abort_no_done", done_seen - base, 0);
        chk("abort_drained", exp_q.size(), 0);

        // Reset in the middle of the CRC field
        do_start(4, 1, 100);
        @(negedge sd_clk); bus.dat_i = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sd_clk); bus.dat_i = 4'(k); exp_q.push_back(4'(k));
        end
        repeat (6) @(negedge sd_clk) bus.dat_i = 4'hF;
        chk("pre_rst_d", int'(bus.d), 8);
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("midrst_d", int'(bus.d), 0);
        chk("midrst_wr", int'(bus.wr), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        @(negedge sd_clk);
        rst = 1'b0;
        chk("midrst_drained", exp_q.size(), 0);
        repeat (5) @(negedge sd_clk);
        chk("post_rst_busy", int'(bus.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sd_data_rx_4bit.md
Name: sd_data_rx_4bit

Overview:
- Upstream neighbour of the SD RX nibble FIFO: the 4-bit SD card data-line receiver.
- Detects the start bit on DAT[3:0], then streams each data nibble to the FIFO as a 4-bit d/wr pair.
- Checks the per-line CRC16 and the end bit, enforces a start-bit timeout, and sequences multi-block reads.
- Runs entirely in the SD clock domain, which is the FIFO's write-clock domain.

Parameters:
- BLK_LEN_W, 12: width of the block-length input, in bytes.
- BLK_CNT_W, 8: width of the block-count input.
- TOUT_W, 16: width of the start-bit timeout counter.

Ports:
- sd_clk  in  1  SD card clock; DAT sampled on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse arming a read; ignored while busy.
- abort  in  1  synchronous abort; returns to IDLE next cycle.
- blk_len  in  BLK_LEN_W  bytes per block (1..4095); sampled at start.
- blk_cnt  in  BLK_CNT_W  blocks to receive (0 treated as 1); sampled at start.
- timeout  in  TOUT_W  sd_clk cycles to wait for each start bit; sampled at start.
- dat_i  in  4  SD DAT[3:0].
- fifo_full  in  1  RX FIFO full flag.
- d  out  4  nibble to FIFO.
- wr  out  1  FIFO write strobe.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse at the end of a transfer (any outcome).
- crc_err  out  1  sticky CRC mismatch on any line.
- end_err  out  1  sticky missing end bit.
- tout_err  out  1  sticky start-bit timeout.
- ovr_err  out  1  sticky: nibble arrived while fifo_full.

Behaviour:
- Reset values: d=0, wr=0, busy=0, done=0, all error flags 0; state IDLE.
- Error flags clear when start is accepted; otherwise they hold until the next accepted start.
- States:
  - IDLE: on start, latch blk_len/blk_cnt/timeout, clear flags -> WAIT_START.
  - WAIT_START: on dat_i==4'h0, clear the four CRCs and the nibble counter -> DATA. Otherwise decrement the timeout counter; on reaching 0, set tout_err -> FINISH. Any partial start pattern (some lines low, some high) is not a start.
  - DATA: each cycle shift bit i of dat_i into CRC[i] and register the nibble. After 2*blk_len nibbles (counter width BLK_LEN_W+1) -> CRC.
  - CRC: 16 cycles; bit i of dat_i shifts into rxcrc[i], MSB first -> ENDB.
  - ENDB: one cycle. dat_i!=4'hF sets end_err. Any rxcrc[i]!=CRC[i] sets crc_err. If blocks remain and no error is set, reload the timeout counter -> WAIT_START; else -> FINISH.
  - FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Nibble ordering: first nibble of each byte is its high nibble; the nibble stream is passed in arrival order with no reordering.
- Output latency: d/wr are registered. The nibble sampled in DATA cycle n appears on d with wr=1 in cycle n+1.
- wr is high for exactly 2*blk_len cycles per block and never during start, CRC or end bits.
- Overrun: if fifo_full is high in the cycle wr would assert, suppress wr, set ovr_err, and continue receiving (CRC still computed) to the end of the block. The transfer then goes to FINISH.
- CRC16-CCITT per line: poly x^16+x^12+x^5+1, init 0. Update: fb=crc[15]^bit; crc={crc[14:0],1'b0}^(fb?16'h1021:0).
- abort in any state: wr=0 next cycle, no done pulse, busy=0, flags held -> IDLE.
- Reset mid-transfer: immediate return to reset values.
- start coincident with abort: abort wins.

Decomposition:
- Package sd_rx_pkg: state enum (IDLE, WAIT_START, DATA, CRC, ENDB, FINISH) and CRC16_POLY=16'h1021.
- Sub-module sd_crc16_serial: 1-bit serial CRC16 with clear and enable, instantiated 4 times.

Test Plan:
- Zero block: blk_len=512, blk_cnt=1, start nibble 0, 1024 nibbles of 0, CRC 0x0000 on all lines, end 4'hF -> 1024 wr pulses with d=0, done after ENDB, no errors.
- Spec vector: blk_len=2048, 4096 nibbles of 4'hF, CRC 0x7FA1 per line -> no crc_err. Flip one CRC bit on line 2 -> crc_err=1, done pulses.
- Timeout: timeout=100, dat_i held 4'hF -> tout_err=1 and done pulses 100 cycles (±1) after start, no wr.
- Multi-block: blk_cnt=3, blk_len=4, nibble pattern 0..7 per block with valid CRCs, 20-cycle gaps -> 24 wr pulses in order, a single done after the third block.
- Overrun/end bit: fifo_full forced high on the 3rd nibble -> that wr suppressed, ovr_err=1, FINISH after block. Separate run with end nibble 4'h7 -> end_err=1.
- Abort/reset: abort asserted mid-DATA -> wr low next cycle, busy=0, no done. rst asserted mid-CRC -> all outputs at reset values immediately.
